// File: rtl/reg_arb_pkg.sv
// Shared widths and the buffered write-entry type for the register-file write arbiter.
package reg_arb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wn;
    logic [REG_DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_arb_if.sv
// Bundle of pipeline writeback, aux handshake, reg_file write port and pending-write query.
interface reg_write_arb_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  logic                   pipe_we;
  logic [REG_AW-1:0]      pipe_wn;
  logic [REG_DW-1:0]      pipe_wd;
  logic                   aux_valid;
  logic                   aux_ready;
  logic [REG_AW-1:0]      aux_wn;
  logic [REG_DW-1:0]      aux_wd;
  logic                   RegWrite;
  logic [REG_AW-1:0]      WN;
  logic [REG_DW-1:0]      WD;
  logic [REG_AW-1:0]      q_rn;
  logic                   q_hit;
  logic [$clog2(DEPTH):0] fifo_cnt;

  modport master (
    output pipe_we, pipe_wn, pipe_wd, aux_valid, aux_wn, aux_wd, q_rn,
    input  aux_ready, RegWrite, WN, WD, q_hit, fifo_cnt
  );

  modport slave (
    input  pipe_we, pipe_wn, pipe_wd, aux_valid, aux_wn, aux_wd, q_rn,
    output aux_ready, RegWrite, WN, WD, q_hit, fifo_cnt
  );

endinterface

// File: rtl/reg_arb_fifo.sv
// Circular aux-result buffer with wrap-bit pointers, per-entry squash clear and q_rn match.
module reg_arb_fifo
  import reg_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  wb_entry_t              i_push_entry,
  input  logic                   i_pop,
  input  logic                   i_squash,
  input  logic [REG_AW-1:0]      i_squash_wn,
  input  logic [REG_AW-1:0]      i_q_rn,
  output wb_entry_t              o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_cnt,
  output logic                   o_q_match
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_cnt;
  logic [DEPTH-1:0] w_occ;
  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_clr;

  assign w_cnt   = r_wr_ptr - r_rd_ptr;
  assign o_cnt   = w_cnt;
  assign o_empty = (w_cnt == '0);
  assign o_full  = (w_cnt == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Slots outside the live window are stale and must never match or be cleared.
  always_comb begin
    w_occ   = '0;
    w_match = '0;
    w_clr   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ[i]   = ({1'b0, AW'(i) - r_rd_ptr[AW-1:0]} < w_cnt);
      w_match[i] = w_occ[i] && r_mem[i].valid && (r_mem[i].wn == i_q_rn);
      w_clr[i]   = i_squash && w_occ[i] && (r_mem[i].wn == i_squash_wn);
    end
  end

  assign o_q_match = |w_match;

  // A same-edge push is written after the clears so a new entry stays valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_clr[i]) r_mem[i].valid <= 1'b0;
      end
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, aux results queue in a FIFO.
// Define REG_ARB_SQUASH_EN to invalidate queued aux writes overtaken by a pipeline write.
module reg_write_arb
  import reg_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_write_arb_if.slave   bus
);

  logic              r_we;
  logic [REG_AW-1:0] r_wn;
  logic [REG_DW-1:0] r_wd;
  logic              w_pipe_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_squash;
  logic              w_empty;
  logic              w_full;
  logic              w_q_match;
  wb_entry_t         w_head;
  wb_entry_t         w_push_entry;

  assign w_pipe_fire  = bus.pipe_we && (bus.pipe_wn != '0);
  assign bus.aux_ready = rst_n && !w_full;
  assign w_push       = bus.aux_valid && bus.aux_ready && (bus.aux_wn != '0);
  assign w_pop        = !w_pipe_fire && !w_empty;
  assign w_push_entry = '{valid: 1'b1, wn: bus.aux_wn, wd: bus.aux_wd};

`ifdef REG_ARB_SQUASH_EN
  assign w_squash = w_pipe_fire;
`else
  assign w_squash = 1'b0;
`endif

  reg_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_squash     (w_squash),
    .i_squash_wn  (bus.pipe_wn),
    .i_q_rn       (bus.q_rn),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_cnt        (bus.fifo_cnt),
    .o_q_match    (w_q_match)
  );

  // Squashed heads pop as bubbles: RegWrite drops while WN/WD hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wn <= '0;
      r_wd <= '0;
    end else if (w_pipe_fire) begin
      r_we <= 1'b1;
      r_wn <= bus.pipe_wn;
      r_wd <= bus.pipe_wd;
    end else if (w_pop) begin
      r_we <= w_head.valid;
      if (w_head.valid) begin
        r_wn <= w_head.wn;
        r_wd <= w_head.wd;
      end
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.RegWrite = r_we;
  assign bus.WN       = r_wn;
  assign bus.WD       = r_wd;
  assign bus.q_hit    = (bus.q_rn != '0) && ((r_we && (r_wn == bus.q_rn)) || w_q_match);

endmodule

// File: tb/tb_reg_write_arb.sv
// Directed plus random stimulus for reg_write_arb against a queue-based reference model.
module tb_reg_write_arb;
  import reg_arb_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic        v;
    logic [4:0]  wn;
    logic [31:0] wd;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wn;
  logic [31:0] m_wd;
  logic        m_init;
  logic [31:0] rf [32];

  reg_write_arb_if #(.DEPTH(DEPTH)) bus ();

  reg_write_arb #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic pwe, input logic [4:0] pwn, input logic [31:0] pwd,
                     input logic av, input logic [4:0] awn, input logic [31:0] awd,
                     input logic [4:0] qrn);
    bus.pipe_we   = pwe;
    bus.pipe_wn   = pwn;
    bus.pipe_wd   = pwd;
    bus.aux_valid = av;
    bus.aux_wn    = awn;
    bus.aux_wd    = awd;
    bus.q_rn      = qrn;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge, check registers.
  task automatic cyc();
    logic exp_rdy;
    logic exp_hit;
    logic acc;
    logic pf;
    ent_t e;
    #1;
    if (!rst_n) begin
      chk("aux_ready_in_reset", {31'd0, bus.aux_ready}, 32'd0);
    end else if (m_init) begin
      exp_rdy = (mq.size() < DEPTH);
      chk("aux_ready", {31'd0, bus.aux_ready}, {31'd0, exp_rdy});
      exp_hit = 1'b0;
      if (bus.q_rn != 5'd0) begin
        if (m_we && m_wn == bus.q_rn) exp_hit = 1'b1;
        foreach (mq[k]) if (mq[k].v && mq[k].wn == bus.q_rn) exp_hit = 1'b1;
      end
      chk("q_hit", {31'd0, bus.q_hit}, {31'd0, exp_hit});
      if (bus.RegWrite === 1'b1) rf[bus.WN] = bus.WD;
    end
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_we   = 1'b0;
      m_wn   = '0;
      m_wd   = '0;
      m_init = 1'b1;
    end else begin
      acc = bus.aux_valid && (mq.size() < DEPTH);
      pf  = bus.pipe_we && (bus.pipe_wn != 5'd0);
`ifdef REG_ARB_SQUASH_EN
      if (pf) foreach (mq[k]) if (mq[k].wn == bus.pipe_wn) mq[k].v = 1'b0;
`endif
      if (pf) begin
        m_we = 1'b1;
        m_wn = bus.pipe_wn;
        m_wd = bus.pipe_wd;
      end else if (mq.size() > 0) begin
        e    = mq.pop_front();
        m_we = e.v;
        if (e.v) begin
          m_wn = e.wn;
          m_wd = e.wd;
        end
      end else begin
        m_we = 1'b0;
      end
      if (acc && bus.aux_wn != 5'd0) mq.push_back('{1'b1, bus.aux_wn, bus.aux_wd});
    end
    #1;
    chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, m_we});
    chk("WN", {27'd0, bus.WN}, {27'd0, m_wn});
    chk("WD", bus.WD, m_wd);
    chk("fifo_cnt", {29'd0, bus.fifo_cnt}, 32'(mq.size()));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_init = 1'b0;
    m_we   = 1'b0;
    m_wn   = '0;
    m_wd   = '0;
    foreach (rf[k]) rf[k] = '0;
    rst_n  = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #2;
    cyc();
    rst_n = 1'b1;

    // Fill three entries behind a pipeline stream, then reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'd9, 32'h900 + 32'(i), 1, 5'(10 + i), 32'hA0 + 32'(i), 5'd10);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 5'd11);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Plain pipeline write lands in the register file one edge later.
    drv(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 5'd5);
    cyc();
    cyc();
    chk("rf5_commit", rf[5], 32'hDEADBEEF);

    // Four aux pushes starved by a continuous pipeline stream, then a drain in order.
    for (int i = 1; i <= 5; i++) begin
      drv(1, 5'd9, 32'h99 + 32'(i), 1, 5'(i), 32'h100 + 32'(i), 5'd3);
      cyc();
    end
    chk("full_cnt", {29'd0, bus.fifo_cnt}, 32'd4);
    drv(0, 0, 0, 0, 0, 0, 5'd3);
    for (int i = 0; i < 5; i++) cyc();

    // Same-edge pipeline and aux write; query follows the aux target.
    drv(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 5'd8);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 5'd8);
    for (int i = 0; i < 3; i++) cyc();

    // Queued write to 6 overtaken by a pipeline write to 6.
    drv(1, 5'd9, 32'h9, 1, 5'd6, 32'h66, 5'd6);
    cyc();
    drv(1, 5'd6, 32'h606, 0, 0, 0, 5'd6);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 5'd6);
    for (int i = 0; i < 3; i++) cyc();

    // Pipeline write to r0 must not block a pop; aux write to r0 is accepted but dropped.
    drv(1, 5'd9, 32'h9, 1, 5'd3, 32'h33, 5'd3);
    cyc();
    drv(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678, 5'd0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 5'd3);
    cyc();

    // Random traffic with small register numbers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)));
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
